// File: rtl/fifo_pkg.sv
// Shared constants and types for the parametrised synchronous FIFO (fifo_sync_param).
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    localparam int DEF_ADDR_W = addr_width(DEF_DEPTH);

    // Wrap bit above the memory address; modules rebuild this layout at their own ADDR_W.
    typedef struct packed {
        logic                  wrap;
        logic [DEF_ADDR_W-1:0] addr;
    } fifo_ptr_t;

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle of fifo_sync_param; master = user logic, slave = FIFO.
interface fifo_sync_param_if #(
    parameter int DATA_W = fifo_pkg::DEF_DATA_W,
    parameter int DEPTH  = fifo_pkg::DEF_DEPTH
);
    localparam int ADDR_W = fifo_pkg::addr_width(DEPTH);

    // WREN/RDEN are requests sampled on the rising clock. There is no separate
    // ready: a write is taken when !full (or a read is taken on the same edge),
    // a read is taken when !empty. Refused requests are dropped and latched in
    // overflow/underflow. Standard mode: read data is on data_out after the edge;
    // FWFT mode: data_out already shows the head and RDEN pops it.
    logic              WREN;
    logic              RDEN;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output WREN, RDEN, data_in,
        input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  WREN, RDEN, data_in,
        output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_dpram.sv
// Two-port FIFO storage: synchronous write, registered read (standard) or
// combinational head read with last-popped hold when FIFO_FWFT_EN is defined.
module fifo_dpram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic              i_valid,
    output logic [DATA_W-1:0] o_rdata
);
    localparam int WORDS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

`ifdef FIFO_FWFT_EN
    logic [DATA_W-1:0] r_last;

    // Keeps the most recently popped word so data_out is stable while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= '0;
        end else if (i_re) begin
            r_last <= r_mem[i_raddr];
        end
    end

    assign o_rdata = i_valid ? r_mem[i_raddr] : r_last;
`else
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re && i_valid) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: pointers, occupancy, thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              reset,
    fifo_sync_param_if.slave  bus
);
    localparam int ADDR_W = addr_width(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_THRESH);

    typedef struct packed {
        logic              wrap;
        logic [ADDR_W-1:0] addr;
    } ptr_t;

    ptr_t              r_wr_ptr;
    ptr_t              r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic              w_valid;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_rdata;

    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr.addr == r_rd_ptr.addr) && (r_wr_ptr.wrap != r_rd_ptr.wrap);
    assign w_valid  = !w_empty;
    assign w_rd_acc = bus.RDEN && !w_empty;
    // A full FIFO still takes a write when a read frees the head slot on the same edge.
    assign w_wr_acc = bus.WREN && (!w_full || w_rd_acc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= ptr_t'(r_wr_ptr + 1'b1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= ptr_t'(r_rd_ptr + 1'b1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.WREN && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (bus.RDEN && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end
        end
    end

    fifo_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr.addr),
        .i_wdata (bus.data_in),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr.addr),
        .i_valid (w_valid),
        .o_rdata (w_rdata)
    );

    assign bus.data_out     = w_rdata;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_empty = (r_count <= AE_LVL);
    assign bus.almost_full  = (r_count >= AF_LVL);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: queue reference model plus popped-data scoreboard.
module tb_fifo_sync_param;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus();

    fifo_sync_param #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_pop = '0;
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
    bit            pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        logic [DW-1:0] exp_dout;
        n = model_q.size();
`ifdef FIFO_FWFT_EN
        exp_dout = (n > 0) ? model_q[0] : last_pop;
`else
        exp_dout = last_pop;
`endif
        chk({tag, ".count"},        32'(bus.count),        32'(n));
        chk({tag, ".empty"},        32'(bus.empty),        32'(n == 0));
        chk({tag, ".full"},         32'(bus.full),         32'(n == DEPTH));
        chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE));
        chk({tag, ".almost_full"},  32'(bus.almost_full),  32'(n >= AF));
        chk({tag, ".overflow"},     32'(bus.overflow),     32'(m_ovf));
        chk({tag, ".underflow"},    32'(bus.underflow),    32'(m_udf));
        chk({tag, ".data_out"},     32'(bus.data_out),     32'(exp_dout));
    endtask

    // One clock of stimulus; the model applies the same request to its queue.
    task automatic cycle(input string tag, input logic wr, input logic rd, input logic [DW-1:0] d);
        bit rd_ok;
        bit wr_ok;
        bus.WREN    = wr;
        bus.RDEN    = rd;
        bus.data_in = d;
        rd_ok = rd && (model_q.size() > 0);
        wr_ok = wr && ((model_q.size() < DEPTH) || rd_ok);
        if (wr && !wr_ok) m_ovf = 1'b1;
        if (rd && !rd_ok) m_udf = 1'b1;
        if (rd_ok) begin
            last_pop = model_q.pop_front();
            exp_q.push_back(last_pop);
        end
        if (wr_ok) model_q.push_back(d);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        bus.WREN    = 1'b0;
        bus.RDEN    = 1'b0;
        bus.data_in = '0;
        #2 reset = 1'b1;
        #1;
        model_q.delete();
        exp_q.delete();
        last_pop = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_state({tag, "_async"});
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check_state({tag, "_released"});
    endtask

    task automatic compare_pop();
        if (exp_q.size() == 0) begin
            chk("mon_unexpected_pop", 32'(1), 32'(0));
        end else begin
            chk("mon_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
        end
    endtask

    // Monitor: compares every word the DUT hands out against the scoreboard queue.
    always @(negedge clk) begin
        if (reset) begin
            pending = 1'b0;
        end else begin
`ifdef FIFO_FWFT_EN
            if (bus.RDEN && !bus.empty) compare_pop();
`else
            if (pending) compare_pop();
            pending = bus.RDEN && !bus.empty;
`endif
        end
    end

    initial begin
        bus.WREN    = 1'b0;
        bus.RDEN    = 1'b0;
        bus.data_in = '0;
        #1;
        do_reset("reset");

        cycle("wr1B", 1'b1, 1'b0, 8'h1B);
        cycle("wr3B", 1'b1, 1'b0, 8'h3B);
        cycle("wr5B", 1'b1, 1'b0, 8'h5B);
        repeat (3) cycle("rd3", 1'b0, 1'b1, '0);

        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, DW'(i));
        cycle("wr_over", 1'b1, 1'b0, 8'hAA);
        repeat (DEPTH) cycle("drain", 1'b0, 1'b1, '0);

        cycle("rd_empty", 1'b0, 1'b1, '0);
        cycle("wr_rd_empty", 1'b1, 1'b1, 8'h7B);
        cycle("rd_7B", 1'b0, 1'b1, '0);

        for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, 1'b0, DW'(8'h40 + i));
        for (int i = 0; i < 20; i++) cycle("wr_rd_full", 1'b1, 1'b1, DW'(8'h80 + i));
        repeat (DEPTH - 5) cycle("to5", 1'b0, 1'b1, '0);
        cycle("idle", 1'b0, 1'b0, '0);
        do_reset("mid_reset");

        cycle("post_wr", 1'b1, 1'b0, 8'hC3);
        cycle("post_rd", 1'b0, 1'b1, '0);
        cycle("idle", 1'b0, 1'b0, '0);

        for (int ph = 0; ph < 3; ph++) begin
            int pw;
            int pr;
            pw = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            pr = 100 - pw;
            for (int i = 0; i < 300; i++) begin
                cycle("rand", 1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) < pr),
                      DW'($urandom_range(0, 255)));
            end
        end

        repeat (DEPTH + 2) cycle("final_drain", 1'b0, 1'b1, '0);
        cycle("idle", 1'b0, 1'b0, '0);
        cycle("idle", 1'b0, 1'b0, '0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous single-clock FIFO built on a two-port memory. Next generation of the team's 8-bit fixed-depth FIFO.
- Generic width and depth.
- Occupancy count and programmable almost-full / almost-empty thresholds.
- Sticky overflow/underflow error flags.
- Sits between producer and consumer logic in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
ADDR_W, $clog2(DEPTH), memory address width (derived, not overridden)
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
WREN  in  1  write request
RDEN  in  1  read request
data_in  in  DATA_W  write data
data_out  out  DATA_W  read data
empty  out  1  no entries stored
full  out  1  DEPTH entries stored
almost_empty  out  1  count <= AE_THRESH
almost_full  out  1  count >= AF_THRESH
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted and dropped
underflow  out  1  sticky: read attempted and dropped

Behaviour:
- Reset values: pointers = 0, count = 0, data_out = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0. Memory contents are not reset.
- Reset is asynchronous on assertion and applies to all state immediately. Reset mid-operation discards all stored data.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (addresses equal) and (wrap bits differ).
  - Pointers wrap naturally modulo 2*DEPTH.
- Accepted write: WREN && (!full || rd_acc). data_in is stored at mem[wr_ptr[ADDR_W-1:0]] and wr_ptr increments.
- Accepted read: RDEN && !empty. The word at rd_ptr is registered to data_out on that edge, so data is valid the cycle after RDEN. rd_ptr increments.
- Full, simultaneous WREN+RDEN: both accepted; count stays DEPTH; full stays 1.
- Empty, simultaneous WREN+RDEN: read rejected, write accepted; data_out holds its value; count becomes 1; underflow is set.
- count update: +1 on write only, -1 on read only, unchanged on both or neither. count is registered; all status flags are derived from registered state (no combinational path from WREN/RDEN to any flag).
- overflow is set on a rejected write; underflow is set on a rejected read. Both flags clear only on reset.
- data_out holds its last value when no read is accepted.
- Write-to-read latency: a word written at edge N is readable (empty = 0) from edge N; RDEN issued in cycle N+1 puts the word on data_out after edge N+2.

Optional Feature:
Macro FIFO_FWFT_EN.
- Defined (first-word-fall-through): data_out always presents the head entry while !empty; RDEN acknowledges/pops it. The next entry is presented the cycle after the pop. Head data is visible in the same cycle empty deasserts. While empty, data_out holds the last popped value.
- Undefined: standard mode, 1-cycle registered read latency as above.
- Flags, count and error behaviour are identical in both modes.

Decomposition:
- Package fifo_pkg:
  - default DATA_W / DEPTH constants
  - function computing the address width
  - typedef for the pointer structure (wrap bit + address)
- Sub-module fifo_dpram: two-port memory with one synchronous write port and one read port (synchronous in standard mode, asynchronous under FIFO_FWFT_EN). The top-level holds only pointers, count, flags and control.

Test Plan:
- Reset and basic write: assert reset, release, write 8'h1B, 8'h3B, 8'h5B -> count 0→3, empty falls after the first edge, no flags set.
- Ordered read: read 3 times -> data_out = 1B, 3B, 5B on successive cycles, each one cycle after RDEN; empty = 1 and count = 0 after the third read.
- Fill to DEPTH = 16 with 0x00..0x0F -> full = 1 and almost_full from count 14. A 17th write (0xAA) sets overflow and is dropped. Reading all 16 returns 0x00..0x0F with no 0xAA.
- Read while empty -> underflow = 1, data_out unchanged. Simultaneous WREN (0x7B) + RDEN while empty -> count = 1, next read returns 0x7B.
- Simultaneous WREN+RDEN while full for 20 cycles with incrementing data -> count stays 16, full stays 1, output sequence continuous with no loss or duplication, including across pointer wrap-around.
- Assert reset mid-stream with count = 5 -> all outputs at reset values immediately (asynchronously); the next write/read pair returns the new data only. Repeat the suite with FIFO_FWFT_EN defined, checking head data visible with zero latency.
